// File: rtl/knn_local_sp_mem_arbiter_if.sv
// Bundles the loader write stream, the distance-engine read request/response streams
// and the single-port search-space buffer port shared by knn_local_sp_mem_arbiter.
interface knn_local_sp_mem_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 11
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;

    logic                  rd_resp_valid;
    logic                  rd_resp_ready;
    logic [DATA_WIDTH-1:0] rd_resp_data;

    logic [ADDR_WIDTH-1:0] mem_address0;
    logic                  mem_ce0;
    logic                  mem_we0;
    logic [DATA_WIDTH-1:0] mem_d0;
    logic [DATA_WIDTH-1:0] mem_q0;

    logic                  err_oob;

    // Master is the surrounding system: producer/consumer streams plus the buffer's q0.
    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_req_valid, rd_req_addr, rd_resp_ready,
        output mem_q0,
        input  wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
        input  mem_address0, mem_ce0, mem_we0, mem_d0, err_oob
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_req_valid, rd_req_addr, rd_resp_ready,
        input  mem_q0,
        output wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
        output mem_address0, mem_ce0, mem_we0, mem_d0, err_oob
    );
endinterface

// File: rtl/knn_local_sp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port search-space buffer between a write stream
// and a credit-limited read stream whose in-order responses drain through a small FIFO.
module knn_local_sp_mem_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 11,
    parameter int ADDR_RANGE = 2048,
    parameter int RD_LATENCY = 1,
    parameter int RESP_DEPTH = 4
) (
    input logic                       clk,
    input logic                       reset,
    knn_local_sp_mem_arbiter_if.slave arb
);
    localparam int          CW      = $clog2(RESP_DEPTH) + 1;
    localparam int          PW      = $clog2(RESP_DEPTH);
    localparam int unsigned RANGE_U = ADDR_RANGE;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    grant_e                last_grant_q, last_grant_d;
    logic [RD_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [RD_LATENCY-1:0] pipe_oob_q, pipe_oob_d;
    logic [CW-1:0]         fifo_count_q, fifo_count_d;
    logic [CW-1:0]         inflight;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [RESP_DEPTH];
    logic                  err_oob_q, err_oob_d;

    logic                  wr_oob, rd_oob;
    logic                  rd_ok, rd_eligible;
    logic                  grant_wr, grant_rd;
    logic                  push, pop, resp_valid;
    logic [DATA_WIDTH-1:0] push_data;

    assign wr_oob = 32'(arb.wr_addr) >= RANGE_U;
    assign rd_oob = 32'(arb.rd_req_addr) >= RANGE_U;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_valid_q[i]);
        end
    end

    // Credits come from start-of-cycle occupancy, so a pop this cycle frees nothing until next cycle.
    assign rd_ok       = ({1'b0, fifo_count_q} + {1'b0, inflight}) < (CW + 1)'(RESP_DEPTH);
    assign rd_eligible = arb.rd_req_valid && rd_ok;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!reset) begin
            if (arb.wr_valid && rd_eligible) begin
                if (last_grant_q == GRANT_READ) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else begin
                grant_wr = arb.wr_valid;
                grant_rd = rd_eligible;
            end
        end
    end

    // OOB requests are still accepted but never reach the buffer.
    always_comb begin
        arb.mem_ce0      = 1'b0;
        arb.mem_we0      = 1'b0;
        arb.mem_address0 = '0;
        arb.mem_d0       = '0;
        if (grant_wr) begin
            arb.mem_ce0      = !wr_oob;
            arb.mem_we0      = !wr_oob;
            arb.mem_address0 = arb.wr_addr;
            arb.mem_d0       = arb.wr_data;
        end else if (grant_rd) begin
            arb.mem_ce0      = !rd_oob;
            arb.mem_address0 = arb.rd_req_addr;
        end
    end

    assign resp_valid        = !reset && (fifo_count_q != '0);
    assign pop               = resp_valid && arb.rd_resp_ready;
    assign push              = pipe_valid_q[RD_LATENCY-1];
    assign push_data         = pipe_oob_q[RD_LATENCY-1] ? '0 : arb.mem_q0;

    assign arb.wr_ready      = grant_wr;
    assign arb.rd_req_ready  = grant_rd;
    assign arb.rd_resp_valid = resp_valid;
    assign arb.rd_resp_data  = fifo_mem_q[rd_ptr_q];
    assign arb.err_oob       = err_oob_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_wr) begin
            last_grant_d = GRANT_WRITE;
        end else if (grant_rd) begin
            last_grant_d = GRANT_READ;
        end

        pipe_valid_d    = '0;
        pipe_oob_d      = '0;
        pipe_valid_d[0] = grant_rd;
        pipe_oob_d[0]   = grant_rd && rd_oob;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_oob_d[i]   = pipe_oob_q[i-1];
        end

        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        err_oob_d    = err_oob_q || (grant_wr && wr_oob) || (grant_rd && rd_oob);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_READ;
            pipe_valid_q <= '0;
            pipe_oob_q   <= '0;
            fifo_count_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            err_oob_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_oob_q   <= pipe_oob_d;
            fifo_count_q <= fifo_count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            err_oob_q    <= err_oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_count_q == CW'(RESP_DEPTH))));
endmodule
